// File: rtl/prng_result_collector_pkg.sv
// Shared constants and types for the PRNG result collector.
package prng_result_collector_pkg;
  localparam int WORD_W        = 128;
  localparam int CSR_START     = 2;
  localparam int CSR_LOAD_SEED = 3;

  localparam logic [2:0] ST_RUNNING = 3'd2;
  localparam logic [2:0] ST_READY   = 3'd1;

  typedef enum logic [1:0] {S_IDLE, S_KICK, S_WAIT} state_t;
endpackage

// File: rtl/rng_result_fifo.sv
// Synchronous FIFO; flush empties it but a same-cycle push still lands.
module rng_result_fifo #(
  parameter int WIDTH = 128,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] pushData,
  input  logic             pop,
  output logic [WIDTH-1:0] headData,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wrPtr, rdPtr;
  logic             doPush, doPop;

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));
  assign doPop  = pop && !empty && !flush;
  // Full FIFO still accepts a push if the head leaves in the same cycle.
  assign doPush = push && (flush || !full || doPop);
  assign headData = empty ? '0 : mem[rdPtr];

  always_ff @(posedge clock)
    if (doPush) mem[wrPtr] <= pushData;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else if (flush) begin
      rdPtr <= wrPtr;
      wrPtr <= doPush ? wrPtr + AW'(1) : wrPtr;
      count <= doPush ? CW'(1) : '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + AW'(1);
      if (doPop)  rdPtr <= rdPtr + AW'(1);
      case ({doPush, doPop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/prng_result_collector.sv
// Host-side PRNG driver: kicks a run, collects result words into a FIFO,
// and feeds the latest word back as the next-iteration seed.
module prng_result_collector
  import prng_result_collector_pkg::*;
#(
  parameter int WORDS_PER_RUN  = 12,
  parameter int FIFO_DEPTH     = 16,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              host_start,
  input  logic              host_load_seed,
  input  logic [WORD_W-1:0] host_seed,
  input  logic              host_clear,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [WORD_W-1:0] rd_data,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic              timeout,
  output logic [2:0]        prng_status,
  output logic [3:0]        csr,
  output logic [WORD_W-1:0] seed,
  output logic [WORD_W-1:0] generated_seed,
  input  logic [2:0]        csr_o,
  input  logic              csr_update,
  input  logic              ctrwrite,
  input  logic [WORD_W-1:0] gen_reg
);
  localparam int CNT_W  = $clog2(WORDS_PER_RUN + 1);
  localparam int TO_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam int FCW    = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORDS_PER_RUN - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TO_W-1:0]  TO_MAX   = TO_W'(TIMEOUT_CYCLES);

  state_t           state;
  logic [CNT_W-1:0] wordCnt;
  logic [TO_W-1:0]  toCnt;
  logic             strobe, popping, fifoFull, fifoEmpty;
  logic [FCW-1:0]   fifoCount;

  assign strobe   = (state == S_WAIT) && ctrwrite;
  assign popping  = rd_ready && !fifoEmpty;
  assign rd_valid = (fifoCount != '0);

  rng_result_fifo #(.WIDTH(WORD_W), .DEPTH(FIFO_DEPTH)) uFifo (
    .clock    (clock),
    .reset_n  (reset_n),
    .flush    (host_clear),
    .push     (strobe),
    .pushData (gen_reg),
    .pop      (rd_ready),
    .headData (rd_data),
    .full     (fifoFull),
    .empty    (fifoEmpty),
    .count    (fifoCount)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state          <= S_IDLE;
      wordCnt        <= '0;
      toCnt          <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      overflow       <= 1'b0;
      timeout        <= 1'b0;
      prng_status    <= '0;
      csr            <= '0;
      seed           <= '0;
      generated_seed <= '0;
    end else begin
      if (csr_update) prng_status <= csr_o;
      if (host_clear) begin
        done     <= 1'b0;
        overflow <= 1'b0;
        timeout  <= 1'b0;
      end
      // A flush makes room, so only a true drop raises overflow.
      if (strobe && fifoFull && !popping && !host_clear) overflow <= 1'b1;

      case (state)
        S_IDLE: if (host_start) begin
          seed                <= host_seed;
          csr                 <= '0;
          csr[CSR_START]      <= 1'b1;
          csr[CSR_LOAD_SEED]  <= host_load_seed;
          done                <= 1'b0;
          wordCnt             <= '0;
          toCnt               <= '0;
          busy                <= 1'b1;
          state               <= S_KICK;
        end
        S_KICK: begin
          csr[CSR_START] <= 1'b0;
          state          <= S_WAIT;
        end
        S_WAIT: begin
          if (ctrwrite) begin
            generated_seed <= gen_reg;
            toCnt          <= '0;
            wordCnt        <= wordCnt + CNT_W'(1);
            if (wordCnt == CNT_LAST) begin
              done  <= 1'b1;
              csr   <= '0;
              busy  <= 1'b0;
              state <= S_IDLE;
            end
          end else if (toCnt == TO_LAST) begin
            timeout <= 1'b1;
            csr     <= '0;
            busy    <= 1'b0;
            state   <= S_IDLE;
          end else if (toCnt != TO_MAX) begin
            toCnt <= toCnt + TO_W'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_prng_result_collector.sv
// Scoreboard bench: strobes push expected words, a negedge monitor checks pops.
module tb_prng_result_collector;
  import prng_result_collector_pkg::*;

  logic              clock = 1'b0;
  logic              reset_n = 1'b0;
  logic              host_start = 1'b0, host_load_seed = 1'b0, host_clear = 1'b0;
  logic [WORD_W-1:0] host_seed = '0;
  logic              rd_valid, rd_ready = 1'b0;
  logic [WORD_W-1:0] rd_data;
  logic              busy, done, overflow, timeout;
  logic [2:0]        prng_status;
  logic [3:0]        csr;
  logic [WORD_W-1:0] seed, generated_seed;
  logic [2:0]        csr_o = '0;
  logic              csr_update = 1'b0, ctrwrite = 1'b0;
  logic [WORD_W-1:0] gen_reg = '0;

  int errors = 0;
  int checks = 0;
  logic [WORD_W-1:0] expQ[$];

  prng_result_collector dut (
    .clock(clock), .reset_n(reset_n), .host_start(host_start),
    .host_load_seed(host_load_seed), .host_seed(host_seed), .host_clear(host_clear),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .busy(busy),
    .done(done), .overflow(overflow), .timeout(timeout), .prng_status(prng_status),
    .csr(csr), .seed(seed), .generated_seed(generated_seed), .csr_o(csr_o),
    .csr_update(csr_update), .ctrwrite(ctrwrite), .gen_reg(gen_reg)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [WORD_W-1:0] act, input logic [WORD_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: a handshake seen at negedge completes on the next rising edge.
  always @(negedge clock) begin
    if (reset_n && rd_valid && rd_ready) begin
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL pop_unexpected: got %0h expected no word", rd_data);
      end else begin
        chk("pop_data", rd_data, expQ.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic startRun(input logic ld, input logic [WORD_W-1:0] sd,
                          input logic [3:0] expKick, input logic [3:0] expWait);
    host_start = 1'b1; host_load_seed = ld; host_seed = sd;
    tick();
    host_start = 1'b0;
    chk("csr_kick", {124'b0, csr}, {124'b0, expKick});
    chk("busy_kick", {127'b0, busy}, 1);
    tick();
    chk("csr_wait", {124'b0, csr}, {124'b0, expWait});
  endtask

  // live: the bench expects the FSM to be in its collecting state.
  task automatic strobe(input logic [WORD_W-1:0] w, input bit live);
    ctrwrite = 1'b1; gen_reg = w;
    if (live && expQ.size() < 16) expQ.push_back(w);
    tick();
    ctrwrite = 1'b0;
  endtask

  task automatic drain();
    rd_ready = 1'b1;
    for (int i = 0; i < 40 && rd_valid; i++) tick();
    rd_ready = 1'b0;
    chk("drain_empty", {127'b0, rd_valid}, 0);
    chk("drain_queue", expQ.size(), 0);
  endtask

  initial begin
    int cyc;
    #12;
    chk("rst_busy", {127'b0, busy}, 0);
    chk("rst_csr", {124'b0, csr}, 0);
    chk("rst_rd_valid", {127'b0, rd_valid}, 0);
    reset_n = 1'b1;
    tick();

    // Run 1: load seed 1, words 1..12.
    startRun(1'b1, 128'h1, 4'b1100, 4'b1000);
    chk("seed_latched", seed, 128'h1);
    for (int i = 1; i <= 12; i++) begin
      strobe(WORD_W'(i), 1'b1);
      if (i == 6) chk("csr_held", {124'b0, csr}, 128'h8);
    end
    chk("run1_done", {127'b0, done}, 1);
    chk("run1_csr", {124'b0, csr}, 0);
    chk("run1_busy", {127'b0, busy}, 0);
    chk("run1_genseed", generated_seed, 128'd12);
    chk("run1_rd_data", rd_data, 128'd1);
    drain();

    // Preload 10 words, then a run that overflows after 6 more.
    startRun(1'b0, 128'h2, 4'b0100, 4'b0000);
    for (int i = 201; i <= 212; i++) strobe(WORD_W'(i), 1'b1);
    rd_ready = 1'b1; tick(); tick(); rd_ready = 1'b0;
    chk("preload_ovf", {127'b0, overflow}, 0);
    startRun(1'b0, 128'h3, 4'b0100, 4'b0000);
    for (int i = 101; i <= 112; i++) strobe(WORD_W'(i), 1'b1);
    chk("ovf_flag", {127'b0, overflow}, 1);
    chk("ovf_done", {127'b0, done}, 1);
    chk("ovf_genseed", generated_seed, 128'd112);
    drain();
    host_clear = 1'b1; tick(); host_clear = 1'b0;
    chk("clear_ovf", {127'b0, overflow}, 0);
    chk("clear_done", {127'b0, done}, 0);

    // Timeout with no strobes.
    startRun(1'b1, 128'h4, 4'b1100, 4'b1000);
    cyc = 0;
    while (!timeout && cyc < 5000) begin tick(); cyc++; end
    chk("to_flag", {127'b0, timeout}, 1);
    chk("to_window", {127'b0, (cyc >= 4090 && cyc <= 4100)}, 1);
    chk("to_busy", {127'b0, busy}, 0);
    chk("to_csr", {124'b0, csr}, 0);
    host_clear = 1'b1; tick(); host_clear = 1'b0;
    chk("to_clear", {127'b0, timeout}, 0);

    // Clear coinciding with a strobe keeps that strobe's word.
    startRun(1'b1, 128'h55, 4'b1100, 4'b1000);
    strobe(128'd301, 1'b1);
    host_clear = 1'b1; expQ.delete();
    strobe(128'd302, 1'b1);
    host_clear = 1'b0;
    chk("clr_strobe_valid", {127'b0, rd_valid}, 1);
    chk("clr_strobe_busy", {127'b0, busy}, 1);
    rd_ready = 1'b1; tick(); rd_ready = 1'b0;
    chk("clr_strobe_one", {127'b0, rd_valid}, 0);
    for (int i = 303; i <= 305; i++) strobe(WORD_W'(i), 1'b1);

    // Reset after the 5th strobe, then ignored strobes.
    reset_n = 1'b0; expQ.delete();
    #1;
    chk("mid_rst_busy", {127'b0, busy}, 0);
    chk("mid_rst_valid", {127'b0, rd_valid}, 0);
    chk("mid_rst_genseed", generated_seed, 0);
    chk("mid_rst_seed", seed, 0);
    chk("mid_rst_csr", {124'b0, csr}, 0);
    tick();
    reset_n = 1'b1;
    tick();
    for (int i = 0; i < 7; i++) strobe(WORD_W'(500 + i), 1'b0);
    chk("post_rst_valid", {127'b0, rd_valid}, 0);
    chk("post_rst_genseed", generated_seed, 0);
    chk("post_rst_done", {127'b0, done}, 0);

    // Status capture.
    csr_o = ST_RUNNING; csr_update = 1'b1; tick();
    chk("status_run", {125'b0, prng_status}, 128'd2);
    csr_o = ST_READY; tick();
    chk("status_ready", {125'b0, prng_status}, 128'd1);
    csr_update = 1'b0; csr_o = 3'd7; tick();
    chk("status_hold", {125'b0, prng_status}, 128'd1);

    // host_start while busy is ignored.
    startRun(1'b1, 128'hABC, 4'b1100, 4'b1000);
    host_start = 1'b1; host_seed = 128'hDEAD; tick(); host_start = 1'b0;
    chk("restart_csr", {124'b0, csr}, 128'h8);
    tick();
    chk("restart_csr2", {124'b0, csr}, 128'h8);
    chk("restart_seed", seed, 128'hABC);
    for (int i = 401; i <= 412; i++) strobe(WORD_W'(i), 1'b1);
    chk("restart_done", {127'b0, done}, 1);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
